div_unit: RTL and testbench

Iterative 32-bit signed integer divider for the processor's multdiv path. It runs one restoring quotient step per cycle and truncates toward zero. A combinational is_not_zero instance checks the latched divisor, which drives divide-by-zero detection. Results go to the writeback stage through the data_result / data_resultRDY / data_exception interface.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 28 ++
 rtl/is_not_zero.sv | 9 +
 rtl/div_unit.sv | 97 +++++++++
 tb/tb_div_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the iterative signed divider.
package div_pkg;

  localparam int WIDTH    = 32;
  localparam int CNT_W    = 6;
  localparam int DIV_LAT  = 33;
  localparam int DIVZ_LAT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Unsigned magnitude; the most negative value maps onto itself.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step on {rem, quo}.
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // rem stays below dvsr <= 2^31, so the shifted remainder always fits in WIDTH+1 bits.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvsr};

  always_comb begin
    quo_next = {quo[WIDTH-2:0], 1'b0};
    rem_next = rem_sh[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      rem_next    = trial[WIDTH-1:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/is_not_zero.sv
// Existing 32-bit zero detector from the multdiv library.
module is_not_zero (
  input  logic [31:0] data,
  output logic        result
);

  assign result = |data;

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed divider: one quotient bit per cycle, truncation toward zero.
module div_unit
  import div_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvsr_reg;
  logic             neg_reg;

  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             dvsr_nz;

  is_not_zero u_dvsr_chk (
    .data   (dvsr_reg),
    .result (dvsr_nz)
  );

  div_step u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .dvsr     (dvsr_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      rem_reg        <= '0;
      quo_reg        <= '0;
      dvsr_reg       <= '0;
      neg_reg        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (ctrl_DIV) begin
            // quo starts as |A| and is shifted out into rem as quotient bits shift in.
            dvsr_reg       <= mag(data_operandB);
            quo_reg        <= mag(data_operandA);
            neg_reg        <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            rem_reg        <= '0;
            cnt_reg        <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            busy           <= 1'b1;
            state_reg      <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          if (!dvsr_nz) begin
            data_result    <= '0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state_reg      <= DONE;
          end else begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= FIX;
          end
        end
        FIX: begin
          data_result    <= neg_reg ? -quo_reg : quo_reg;
          data_exception <= 1'b0;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state_reg      <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, random vectors vs. arithmetic model, control corner cases.
module tb_div_unit;
  import div_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int errors = 0;
  int checks = 0;

  div_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed quotient truncated toward zero, reduced modulo 2^32; {exception, result}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    if (b == 32'd0) return {1'b1, 32'd0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    return {1'b0, q[31:0]};
  endfunction

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc);
    int lat;
    bit busy_ok;
    int exp_lat;
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    chk({name, "/busy_accept"}, busy, 1);
    chk({name, "/result_cleared"}, data_result, 0);
    lat = 0;
    busy_ok = 1'b1;
    while (!data_resultRDY && lat < 50) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    exp_lat = exp_exc ? DIVZ_LAT : DIV_LAT;
    $display("div %s a=%h b=%h res=%h exc=%b lat=%0d", name, a, b, data_result, data_exception, lat);
    chk({name, "/latency"}, lat, exp_lat);
    chk({name, "/result"}, data_result, exp_res);
    chk({name, "/exception"}, data_exception, exp_exc);
    chk({name, "/busy_in_flight"}, busy_ok, 1);
    chk({name, "/busy_done"}, busy, 0);
    @(posedge clock); #1;
    chk({name, "/rdy_one_cycle"}, data_resultRDY, 0);
    chk({name, "/result_held"}, data_result, exp_res);
  endtask

  initial begin
    vec_t        tbl[12];
    logic [32:0] m;
    logic [31:0] ra, rb, r1, r2;
    int          first, second, lat;
    bit          rdy_seen;

    tbl[0]  = '{"100/7",      32'd100,        32'd7,          32'h0000000E, 1'b0};
    tbl[1]  = '{"-100/7",     32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 1'b0};
    tbl[2]  = '{"-7/2",       32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 1'b0};
    tbl[3]  = '{"7/-2",       32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 1'b0};
    tbl[4]  = '{"-7/-2",      32'hFFFFFFF9,   32'hFFFFFFFE,   32'h00000003, 1'b0};
    tbl[5]  = '{"7/0",        32'd7,          32'd0,          32'h00000000, 1'b1};
    tbl[6]  = '{"9/3",        32'd9,          32'd3,          32'h00000003, 1'b0};
    tbl[7]  = '{"min/-1",     32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b0};
    tbl[8]  = '{"0/5",        32'd0,          32'd5,          32'h00000000, 1'b0};
    tbl[9]  = '{"max/1",      32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF, 1'b0};
    tbl[10] = '{"min/min",    32'h80000000,   32'h80000000,   32'h00000001, 1'b0};
    tbl[11] = '{"min/2",      32'h80000000,   32'd2,          32'hC0000000, 1'b0};

    // Reset state
    @(posedge clock); #1;
    chk("reset/result", data_result, 0);
    chk("reset/exception", data_exception, 0);
    chk("reset/rdy", data_resultRDY, 0);
    chk("reset/busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (tbl[i]) run_div(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = -($urandom_range(1, 1000));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 8 == 7) rb = 32'd0;
      m = model(ra, rb);
      run_div($sformatf("rand%0d", i), ra, rb, m[31:0], m[32]);
    end

    // ctrl_DIV held high for 40 cycles while operands change: first result from latched 100/7,
    // then a second accept in DONE picks up 1000/10.
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    @(posedge clock); #1;
    first = -1; second = -1; r1 = '0; r2 = '0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        if (first < 0) begin first = cyc; r1 = data_result; end
        else if (second < 0) begin second = cyc; r2 = data_result; end
      end
      if (cyc < 20) begin
        data_operandA = $urandom;
        data_operandB = $urandom;
      end else if (cyc == 20) begin
        data_operandA = 32'd1000;
        data_operandB = 32'd10;
      end
      if (cyc == 39) ctrl_DIV = 1'b0;
    end
    $display("held first=%0d res=%h second=%0d res=%h", first, r1, second, r2);
    chk("held/first_cycle", first, 33);
    chk("held/first_result", r1, 32'd14);
    chk("held/second_cycle", second, 67);
    chk("held/second_result", r2, 32'd100);

    // Back-to-back: start issued in the DONE cycle of 9/3.
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    lat = 0;
    while (!data_resultRDY && lat < 50) begin @(posedge clock); #1; lat++; end
    chk("b2b/first_result", data_result, 32'd3);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    chk("b2b/busy_accept", busy, 1);
    lat = 0;
    while (!data_resultRDY && lat < 50) begin @(posedge clock); #1; lat++; end
    $display("b2b second res=%h lat=%0d", data_result, lat);
    chk("b2b/latency", lat, 33);
    chk("b2b/result", data_result, 32'd10);
    @(posedge clock); #1;

    // Asynchronous reset mid-operation.
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (9) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid/busy", busy, 0);
    chk("rst_mid/result", data_result, 0);
    chk("rst_mid/exception", data_exception, 0);
    chk("rst_mid/rdy", data_resultRDY, 0);
    rdy_seen = 1'b0;
    repeat (2) begin @(posedge clock); #1; if (data_resultRDY) rdy_seen = 1'b1; end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) begin @(posedge clock); #1; if (data_resultRDY || busy) rdy_seen = 1'b1; end
    $display("rst_mid activity_after_reset=%b", rdy_seen);
    chk("rst_mid/no_rdy", rdy_seen, 0);
    run_div("post_reset_100/7", 32'd100, 32'd7, 32'h0000000E, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
